// File: rtl/neural_layer_ctrl_pkg.sv
// Shared definitions for the neural layer controller family.
// Holds the 3-bit state encodings (kept as plain localparams so that future
// network-level sequencers can reuse the same numbering), the state enum built
// on top of them, and an index-width helper.
package neural_layer_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BIAS  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_ACT   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_BIAS  = ST_BIAS,
        S_MAC   = ST_MAC,
        S_ACT   = ST_ACT,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE
    } state_t;

    // Width of an index that counts 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nn_index_counter.sv
// Parameterised modulo index counter.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   i_clear     - synchronous clear to 0 (has priority over i_inc)
//   i_inc       - advance by one, wrapping from MODULUS-1 back to 0
//   o_count     - current index (register output)
//   o_last      - high while o_count == MODULUS-1
module nn_index_counter #(
    parameter int unsigned MODULUS = 2,
    parameter int unsigned W       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    localparam logic [W-1:0] LAST_VAL = W'(MODULUS - 32'd1);

    logic [W-1:0] r_count;

    // Index register: clear wins over increment, wrap at the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_clear) begin
            r_count <= {W{1'b0}};
        end else if (i_inc) begin
            if (r_count == LAST_VAL) begin
                r_count <= {W{1'b0}};
            end else begin
                r_count <= r_count + W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_VAL);

endmodule

// File: rtl/neural_layer_ctrl.sv
// Sequencer for one fully connected layer evaluated on an external float
// multiply-accumulate unit. For each neuron: load bias, issue IN_SIZE MAC
// requests, optionally request the activation, then write the result.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - run one layer (only honoured in IDLE)
//   busy, done            - status; done is a one-cycle pulse
//   in_addr, w_addr       - input-vector and weight indices for the MAC
//   b_addr                - bias index (= neuron)
//   acc_load              - load bias[b_addr] into the accumulator
//   mac_valid/mac_ready   - MAC request handshake
//   act_valid/act_ready   - activation request handshake
//   out_we, out_addr      - result write strobe and index (= neuron)
// Every output is a flop; strobes are registered from the next state so they
// line up exactly with the state they belong to.
module neural_layer_ctrl
    import neural_layer_ctrl_pkg::*;
#(
    parameter int unsigned IN_SIZE    = 25,
    parameter int unsigned OUT_SIZE   = 20,
    parameter int unsigned ACTIVATION = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [idx_width(IN_SIZE)-1:0]              in_addr,
    output logic [idx_width(IN_SIZE*OUT_SIZE)-1:0]     w_addr,
    output logic [idx_width(OUT_SIZE)-1:0]             b_addr,
    output logic                                       acc_load,
    output logic                                       mac_valid,
    input  logic                                       mac_ready,
    output logic                                       act_valid,
    input  logic                                       act_ready,
    output logic                                       out_we,
    output logic [idx_width(OUT_SIZE)-1:0]             out_addr
);

    localparam int unsigned IW = idx_width(IN_SIZE);
    localparam int unsigned OW = idx_width(OUT_SIZE);
    localparam int unsigned WW = idx_width(IN_SIZE * OUT_SIZE);

    state_t          r_state;
    state_t          w_next;
    logic            r_busy;
    logic            r_done;
    logic            r_acc_load;
    logic            r_mac_valid;
    logic            r_act_valid;
    logic            r_out_we;
    logic [WW-1:0]   r_w_addr;

    logic            w_start;
    logic            w_mac_hs;
    logic            w_act_hs;
    logic            w_neuron_inc;
    logic [IW-1:0]   w_in_idx;
    logic            w_in_last;
    logic [OW-1:0]   w_n_idx;
    logic            w_n_last;

    assign w_start      = (r_state == S_IDLE) && start;
    assign w_mac_hs     = r_mac_valid && mac_ready;
    assign w_act_hs     = r_act_valid && act_ready;
    // The neuron index never wraps: the last WRITE goes to DONE instead.
    assign w_neuron_inc = (r_state == S_WRITE) && !w_n_last;

    nn_index_counter #(
        .MODULUS (IN_SIZE),
        .W       (IW)
    ) u_input_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_inc   (w_mac_hs),
        .o_count (w_in_idx),
        .o_last  (w_in_last)
    );

    nn_index_counter #(
        .MODULUS (OUT_SIZE),
        .W       (OW)
    ) u_neuron_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_inc   (w_neuron_inc),
        .o_count (w_n_idx),
        .o_last  (w_n_last)
    );

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_BIAS;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BIAS: begin
                w_next = S_MAC;
            end
            S_MAC: begin
                if (w_mac_hs && w_in_last) begin
                    if (ACTIVATION != 32'd0) begin
                        w_next = S_ACT;
                    end else begin
                        w_next = S_WRITE;
                    end
                end else begin
                    w_next = S_MAC;
                end
            end
            S_ACT: begin
                if (w_act_hs) begin
                    w_next = S_WRITE;
                end else begin
                    w_next = S_ACT;
                end
            end
            S_WRITE: begin
                if (w_n_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_BIAS;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered strobes and status, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_load  <= 1'b0;
            r_mac_valid <= 1'b0;
            r_act_valid <= 1'b0;
            r_out_we    <= 1'b0;
        end else begin
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            r_acc_load  <= (w_next == S_BIAS);
            r_mac_valid <= (w_next == S_MAC);
            r_act_valid <= (w_next == S_ACT);
            r_out_we    <= (w_next == S_WRITE);
        end
    end

    // Weight index runs linearly across neurons, so neuron*IN_SIZE + input
    // is just the number of MAC handshakes since start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_addr <= {WW{1'b0}};
        end else if (w_start) begin
            r_w_addr <= {WW{1'b0}};
        end else if (w_mac_hs) begin
            r_w_addr <= r_w_addr + WW'(1);
        end else begin
            r_w_addr <= r_w_addr;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign acc_load  = r_acc_load;
    assign mac_valid = r_mac_valid;
    assign act_valid = r_act_valid;
    assign out_we    = r_out_we;
    assign in_addr   = w_in_idx;
    assign w_addr    = r_w_addr;
    assign b_addr    = w_n_idx;
    assign out_addr  = w_n_idx;

endmodule

// File: tb/tb_neural_layer_ctrl.sv
// Directed bench for neural_layer_ctrl. Three instances cover
// (IN,OUT,ACT) = (3,2,1), (3,2,0) and (1,1,1). Cycle numbering: the cycle
// whose closing edge samples start is cycle 0; outputs are sampled 1 ns after
// each rising edge.
module tb_neural_layer_ctrl;

    logic clk;
    logic rst_n;
    logic [2:0] start_v;
    logic [2:0] mac_ready_v;
    logic [2:0] act_ready_v;
    logic [2:0] busy_v, done_v, acc_v, mac_v, act_v, we_v;

    logic [1:0] a_in_addr, b_in_addr;
    logic [2:0] a_w_addr,  b_w_addr;
    logic [0:0] a_b_addr,  b_b_addr, a_out_addr, b_out_addr;
    logic [0:0] c_in_addr, c_w_addr, c_b_addr, c_out_addr;

    int n_vec = 0;
    int n_bad = 0;
    int sel   = 0;

    logic       m_busy, m_done, m_acc, m_mac, m_act, m_we;
    logic [7:0] m_in_addr, m_w_addr, m_b_addr, m_out_addr;

    int wq[$];
    int oq[$];
    int act_cnt;
    int first_acc, first_mac, first_act, first_we;
    int done_cyc;

    neural_layer_ctrl #(.IN_SIZE(3), .OUT_SIZE(2), .ACTIVATION(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .in_addr(a_in_addr), .w_addr(a_w_addr), .b_addr(a_b_addr), .acc_load(acc_v[0]),
        .mac_valid(mac_v[0]), .mac_ready(mac_ready_v[0]), .act_valid(act_v[0]),
        .act_ready(act_ready_v[0]), .out_we(we_v[0]), .out_addr(a_out_addr));

    neural_layer_ctrl #(.IN_SIZE(3), .OUT_SIZE(2), .ACTIVATION(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .in_addr(b_in_addr), .w_addr(b_w_addr), .b_addr(b_b_addr), .acc_load(acc_v[1]),
        .mac_valid(mac_v[1]), .mac_ready(mac_ready_v[1]), .act_valid(act_v[1]),
        .act_ready(act_ready_v[1]), .out_we(we_v[1]), .out_addr(b_out_addr));

    neural_layer_ctrl #(.IN_SIZE(1), .OUT_SIZE(1), .ACTIVATION(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .in_addr(c_in_addr), .w_addr(c_w_addr), .b_addr(c_b_addr), .acc_load(acc_v[2]),
        .mac_valid(mac_v[2]), .mac_ready(mac_ready_v[2]), .act_valid(act_v[2]),
        .act_ready(act_ready_v[2]), .out_we(we_v[2]), .out_addr(c_out_addr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance onto the monitor signals.
    always_comb begin
        m_busy = busy_v[sel]; m_done = done_v[sel]; m_acc = acc_v[sel];
        m_mac  = mac_v[sel];  m_act  = act_v[sel];  m_we  = we_v[sel];
        case (sel)
            0: begin
                m_in_addr = {6'd0, a_in_addr}; m_w_addr = {5'd0, a_w_addr};
                m_b_addr  = {7'd0, a_b_addr};  m_out_addr = {7'd0, a_out_addr};
            end
            1: begin
                m_in_addr = {6'd0, b_in_addr}; m_w_addr = {5'd0, b_w_addr};
                m_b_addr  = {7'd0, b_b_addr};  m_out_addr = {7'd0, b_out_addr};
            end
            default: begin
                m_in_addr = {7'd0, c_in_addr}; m_w_addr = {7'd0, c_w_addr};
                m_b_addr  = {7'd0, c_b_addr};  m_out_addr = {7'd0, c_out_addr};
            end
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse (or hold) start on instance 'which' and follow it cycle by cycle
    // until done, an abort cycle, or a cycle budget. mac_ready is low for
    // stall_len cycles from stall_at; during those cycles w_addr must stay at stall_w.
    task automatic run(input int which, input int stall_at, input int stall_len,
                       input int stall_w, input bit hold_start, input int abort_at);
        int c;
        sel = which;
        wq.delete(); oq.delete();
        act_cnt = 0; first_acc = -1; first_mac = -1; first_act = -1; first_we = -1;
        done_cyc = -1;
        @(negedge clk);
        start_v[which] = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start_v[which] = 1'b0;
        c = 1;
        while (c < 200) begin
            mac_ready_v[which] = !(c >= stall_at && c < stall_at + stall_len);
            check("onehot", int'($onehot0({m_acc, m_mac, m_act, m_we, m_done})), 1);
            if (m_acc && first_acc < 0) first_acc = c;
            if (m_mac && first_mac < 0) first_mac = c;
            if (m_act && first_act < 0) first_act = c;
            if (m_we  && first_we  < 0) first_we  = c;
            if (m_act) act_cnt++;
            if (m_mac && mac_ready_v[which]) wq.push_back(int'(m_w_addr));
            if (m_mac && !mac_ready_v[which]) check("stall_w_addr", int'(m_w_addr), stall_w);
            if (m_we) oq.push_back(int'(m_out_addr));
            if (m_done) begin
                done_cyc = c;
                break;
            end
            if (c == abort_at) break;
            @(posedge clk); #1;
            c++;
        end
        mac_ready_v[which] = 1'b1;
        if (abort_at < 0) check("done_reached", int'(done_cyc >= 0), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (!m_busy) break;
            @(posedge clk); #1;
        end
        check("idle_timeout", int'(m_busy), 0);
    endtask

    task automatic check_seq6(input string tag);
        check({tag, "_len"}, wq.size(), 6);
        for (int i = 0; i < wq.size() && i < 6; i++) check(tag, wq[i], i);
    endtask

    initial begin
        rst_n = 1'b0;
        start_v = 3'b000;
        mac_ready_v = 3'b111;
        act_ready_v = 3'b111;
        #23;
        // Reset state of every instance
        check("rst_busy", int'(busy_v), 0);
        check("rst_strobes", int'({done_v, acc_v, mac_v, act_v, we_v}), 0);
        check("rst_addr_a", int'({a_in_addr, a_w_addr, a_b_addr, a_out_addr}), 0);

        // Basic run, start on the first edge after reset release
        @(posedge clk); #1; rst_n = 1'b1;
        run(0, 0, 0, 0, 1'b0, -1);
        check("basic_done_cyc", done_cyc, 13);
        check_seq6("basic_w_addr");
        check("basic_we_cnt", oq.size(), 2);
        if (oq.size() == 2) begin
            check("basic_out_addr0", oq[0], 0);
            check("basic_out_addr1", oq[1], 1);
        end
        check("basic_act_cnt", act_cnt, 2);
        @(posedge clk); #1;
        check("basic_idle_busy", int'(m_busy), 0);

        // Backpressure: neuron 0 input 1 is in MAC during cycle 3
        run(0, 3, 5, 1, 1'b0, -1);
        check("bp_done_cyc", done_cyc, 18);
        check_seq6("bp_w_addr");
        @(posedge clk); #1;

        // No activation step
        run(1, 0, 0, 0, 1'b0, -1);
        check("noact_done_cyc", done_cyc, 11);
        check("noact_act_cnt", act_cnt, 0);
        check_seq6("noact_w_addr");
        @(posedge clk); #1;

        // Start held high: one run, then an IDLE cycle, then a fresh run
        run(0, 0, 0, 0, 1'b1, -1);
        check("hold_done_cyc", done_cyc, 13);
        check("hold_we_cnt", oq.size(), 2);
        @(posedge clk); #1;
        check("hold_gap_busy", int'(m_busy), 0);
        @(posedge clk); #1;
        check("hold_restart_acc", int'(m_acc), 1);
        check("hold_restart_b", int'(m_b_addr), 0);
        start_v[0] = 1'b0;
        wait_idle();
        @(posedge clk); #1;

        // Mid-run reset during neuron 1 MAC (cycle 8)
        run(0, 0, 0, 0, 1'b0, 8);
        check("mid_b_addr", int'(m_b_addr), 1);
        check("mid_mac", int'(m_mac), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(m_busy), 0);
        check("mid_rst_strobes", int'({m_done, m_acc, m_mac, m_act, m_we}), 0);
        check("mid_rst_addr", int'({a_in_addr, a_w_addr, a_b_addr, a_out_addr}), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        run(0, 0, 0, 0, 1'b0, -1);
        check("mid_rerun_done_cyc", done_cyc, 13);
        check_seq6("mid_rerun_w_addr");
        @(posedge clk); #1;

        // Degenerate 1x1 layer
        run(2, 0, 0, 0, 1'b0, -1);
        check("deg_acc_cyc", first_acc, 1);
        check("deg_mac_cyc", first_mac, 2);
        check("deg_act_cyc", first_act, 3);
        check("deg_we_cyc",  first_we,  4);
        check("deg_done_cyc", done_cyc, 5);
        @(posedge clk); #1;
        check("deg_idle_busy", int'(m_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
